ngy_grid_renderer: RTL and testbench

Downstream consumer of the snake game's 30x40 LED grid bitmap. Generates a 320x240 raster with a per-pixel clock enable derived from clk_74a, and latches the grid once per frame into a tear-free frame buffer. Scales each grid cell to an 8x8 pixel block and drives RGB plus sync/DE toward the Pocket video path. Emits a one-cycle frame_start pulse the game logic can use as a tick source.

---
 rtl/ngy_video_pkg.sv | 40 ++++
 rtl/ngy_grid_renderer_if.sv | 30 +++
 rtl/ngy_video_timing.sv | 78 +++++++
 rtl/ngy_grid_renderer.sv | 136 +++++++++++++
 tb/tb_ngy_grid_renderer.sv | 237 +++++++++++++++++++++++
 5 files changed

// File: rtl/ngy_video_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ngy_video_pkg
// Description : Shared raster timing, colour and grid constants for the
//               snake game video path.
// Revision    : 1.0
// ============================================================================
package ngy_video_pkg;

    typedef logic [23:0] rgb_t;

    // Raw raster qualifiers; field order matches the S1/S2 pipeline packing.
    typedef struct packed {
        logic active;
        logic hs;
        logic vs;
    } raster_t;

    localparam int c_grid_rows = 30;
    localparam int c_grid_cols = 40;
    localparam int c_cell_px   = 8;
    localparam int c_pix_div   = 12;

    localparam int c_h_active  = 320;
    localparam int c_h_fp      = 16;
    localparam int c_h_sync    = 32;
    localparam int c_h_bp      = 32;
    localparam int c_h_total   = c_h_active + c_h_fp + c_h_sync + c_h_bp;

    localparam int c_v_active  = 240;
    localparam int c_v_fp      = 4;
    localparam int c_v_sync    = 4;
    localparam int c_v_bp      = 12;
    localparam int c_v_total   = c_v_active + c_v_fp + c_v_sync + c_v_bp;

    localparam rgb_t c_fg_color = 24'h00FF00;
    localparam rgb_t c_bg_color = 24'h000000;

endpackage : ngy_video_pkg
`default_nettype wire

// File: rtl/ngy_grid_renderer_if.sv
`default_nettype none
// ============================================================================
// Module      : ngy_grid_renderer_if
// Description : Grid bitmap in, raster video out between game and video path.
// Revision    : 1.0
// ============================================================================
interface ngy_grid_renderer_if
    import ngy_video_pkg::*;
#(
    parameter int N_CELLS = c_grid_rows * c_grid_cols
);
    logic [0:N_CELLS-1] grid_ram;
    logic               pix_ce;
    rgb_t               video_rgb;
    logic               video_hs;
    logic               video_vs;
    logic               video_de;
    logic               frame_start;

    modport master (
        input  grid_ram,
        output pix_ce, video_rgb, video_hs, video_vs, video_de, frame_start
    );

    modport slave (
        output grid_ram,
        input  pix_ce, video_rgb, video_hs, video_vs, video_de, frame_start
    );
endinterface : ngy_grid_renderer_if
`default_nettype wire

// File: rtl/ngy_video_timing.sv
`default_nettype none
// ============================================================================
// Module      : ngy_video_timing
// Description : Pixel clock-enable divider, h/v raster counters, raw sync
//               qualifiers and the once-per-frame snapshot strobe.
// Revision    : 1.0
// ============================================================================
module ngy_video_timing
    import ngy_video_pkg::*;
#(
    parameter int PIX_DIV  = c_pix_div,
    parameter int H_ACTIVE = c_h_active,
    parameter int H_FP     = c_h_fp,
    parameter int H_SYNC   = c_h_sync,
    parameter int H_BP     = c_h_bp,
    parameter int V_ACTIVE = c_v_active,
    parameter int V_FP     = c_v_fp,
    parameter int V_SYNC   = c_v_sync,
    parameter int V_BP     = c_v_bp
) (
    input  logic                                           clk_74a,
    input  logic                                           reset,
    output logic                                           o_pix_ce,
    output logic [$clog2(H_ACTIVE+H_FP+H_SYNC+H_BP)-1:0]   o_h,
    output logic [$clog2(V_ACTIVE+V_FP+V_SYNC+V_BP)-1:0]   o_v,
    output logic                                           o_active,
    output logic                                           o_hs,
    output logic                                           o_vs,
    output logic                                           o_snap
);
    localparam int c_h_tot = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int c_v_tot = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int c_hw    = $clog2(c_h_tot);
    localparam int c_vw    = $clog2(c_v_tot);
    localparam int c_dw    = $clog2(PIX_DIV);

    logic [c_dw-1:0] r_div;
    logic [c_hw-1:0] r_h;
    logic [c_vw-1:0] r_v;
    logic            w_pix_ce;

    assign w_pix_ce = (r_div == c_dw'(PIX_DIV - 1));

    always_ff @(posedge clk_74a) begin
        if (reset) begin
            r_div <= '0;
        end else if (w_pix_ce) begin
            r_div <= '0;
        end else begin
            r_div <= r_div + 1'b1;
        end
    end

    always_ff @(posedge clk_74a) begin
        if (reset) begin
            r_h <= '0;
            r_v <= '0;
        end else if (w_pix_ce) begin
            if (int'(r_h) == c_h_tot - 1) begin
                r_h <= '0;
                r_v <= (int'(r_v) == c_v_tot - 1) ? '0 : r_v + 1'b1;
            end else begin
                r_h <= r_h + 1'b1;
            end
        end
    end

    assign o_pix_ce = w_pix_ce;
    assign o_h      = r_h;
    assign o_v      = r_v;
    assign o_active = (int'(r_h) < H_ACTIVE) && (int'(r_v) < V_ACTIVE);
    assign o_hs     = (int'(r_h) >= H_ACTIVE + H_FP) && (int'(r_h) < H_ACTIVE + H_FP + H_SYNC);
    assign o_vs     = (int'(r_v) >= V_ACTIVE + V_FP) && (int'(r_v) < V_ACTIVE + V_FP + V_SYNC);
    // First pixel of the first blanking line: the whole visible frame has been scanned.
    assign o_snap   = w_pix_ce && (r_h == '0) && (int'(r_v) == V_ACTIVE);

endmodule : ngy_video_timing
`default_nettype wire

// File: rtl/ngy_grid_renderer.sv
`default_nettype none
// ============================================================================
// Module      : ngy_grid_renderer
// Description : Scales the snake grid bitmap to a CELL_PX-blocked raster with
//               a tear-free per-frame snapshot and a 2-pixel output pipeline.
// Revision    : 1.0
// ============================================================================
module ngy_grid_renderer
    import ngy_video_pkg::*;
#(
    parameter int   GRID_ROWS = c_grid_rows,
    parameter int   GRID_COLS = c_grid_cols,
    parameter int   CELL_PX   = c_cell_px,
    parameter int   PIX_DIV   = c_pix_div,
    parameter int   H_ACTIVE  = c_h_active,
    parameter int   H_FP      = c_h_fp,
    parameter int   H_SYNC    = c_h_sync,
    parameter int   H_BP      = c_h_bp,
    parameter int   V_ACTIVE  = c_v_active,
    parameter int   V_FP      = c_v_fp,
    parameter int   V_SYNC    = c_v_sync,
    parameter int   V_BP      = c_v_bp,
    parameter rgb_t FG_COLOR  = c_fg_color,
    parameter rgb_t BG_COLOR  = c_bg_color
) (
    input  logic                clk_74a,
    input  logic                reset,
    ngy_grid_renderer_if.master vid
);
    localparam int c_n_cells = GRID_ROWS * GRID_COLS;
    localparam int c_shift   = $clog2(CELL_PX);
    localparam int c_col_w   = $clog2(GRID_COLS);
    localparam int c_row_w   = $clog2(GRID_ROWS);
    localparam int c_idx_w   = $clog2(c_n_cells);
    localparam int c_hw      = $clog2(H_ACTIVE + H_FP + H_SYNC + H_BP);
    localparam int c_vw      = $clog2(V_ACTIVE + V_FP + V_SYNC + V_BP);

    if (GRID_COLS * CELL_PX != H_ACTIVE) begin : g_chk_cols
        $error("ngy_grid_renderer: GRID_COLS*CELL_PX must equal H_ACTIVE");
    end
    if (GRID_ROWS * CELL_PX != V_ACTIVE) begin : g_chk_rows
        $error("ngy_grid_renderer: GRID_ROWS*CELL_PX must equal V_ACTIVE");
    end
    if (PIX_DIV < 2) begin : g_chk_div
        $error("ngy_grid_renderer: PIX_DIV must be at least 2");
    end
    if ((1 << c_shift) != CELL_PX) begin : g_chk_cell
        $error("ngy_grid_renderer: CELL_PX must be a power of two");
    end

    logic               w_pix_ce;
    logic               w_snap;
    logic [c_hw-1:0]    w_h;
    logic [c_vw-1:0]    w_v;
    logic               w_active;
    logic               w_hs;
    logic               w_vs;
    raster_t            w_raw;
    logic [c_idx_w-1:0] w_idx;

    logic [0:c_n_cells-1] r_frame_buf;
    logic [c_col_w-1:0]   r_s1_col;
    logic [c_row_w-1:0]   r_s1_row;
    raster_t              r_s1;
    rgb_t                 r_rgb;
    raster_t              r_s2;

    ngy_video_timing #(
        .PIX_DIV  (PIX_DIV),
        .H_ACTIVE (H_ACTIVE),
        .H_FP     (H_FP),
        .H_SYNC   (H_SYNC),
        .H_BP     (H_BP),
        .V_ACTIVE (V_ACTIVE),
        .V_FP     (V_FP),
        .V_SYNC   (V_SYNC),
        .V_BP     (V_BP)
    ) u_timing (
        .clk_74a  (clk_74a),
        .reset    (reset),
        .o_pix_ce (w_pix_ce),
        .o_h      (w_h),
        .o_v      (w_v),
        .o_active (w_active),
        .o_hs     (w_hs),
        .o_vs     (w_vs),
        .o_snap   (w_snap)
    );

    assign w_raw = {w_active, w_hs, w_vs};

    // The snapshot lands in blanking, so no visible pixel ever mixes two frames.
    always_ff @(posedge clk_74a) begin
        if (reset) begin
            r_frame_buf <= '0;
        end else if (w_snap) begin
            r_frame_buf <= vid.grid_ram;
        end
    end

    always_ff @(posedge clk_74a) begin
        if (reset) begin
            r_s1_col <= '0;
            r_s1_row <= '0;
            r_s1     <= '0;
        end else if (w_pix_ce) begin
            r_s1_col <= c_col_w'(w_h >> c_shift);
            r_s1_row <= c_row_w'(w_v >> c_shift);
            r_s1     <= w_raw;
        end
    end

    // Outside the active window the truncated cell coordinates may alias; force index 0.
    assign w_idx = r_s1.active
                 ? c_idx_w'(int'(r_s1_row) * GRID_COLS + int'(r_s1_col))
                 : '0;

    always_ff @(posedge clk_74a) begin
        if (reset) begin
            r_rgb <= '0;
            r_s2  <= '0;
        end else if (w_pix_ce) begin
            r_rgb <= r_s1.active ? (r_frame_buf[w_idx] ? FG_COLOR : BG_COLOR) : '0;
            r_s2  <= r_s1;
        end
    end

    assign vid.pix_ce      = w_pix_ce;
    assign vid.frame_start = w_snap;
    assign vid.video_rgb   = r_rgb;
    assign vid.video_de    = r_s2.active;
    assign vid.video_hs    = r_s2.hs;
    assign vid.video_vs    = r_s2.vs;

endmodule : ngy_grid_renderer
`default_nettype wire

// File: tb/tb_ngy_grid_renderer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_ngy_grid_renderer
// Description : Scoreboard bench for ngy_grid_renderer on a reduced raster.
// Revision    : 1.0
// ============================================================================
module tb_ngy_grid_renderer;
    import ngy_video_pkg::*;

    localparam int GR  = 3;
    localparam int GC  = 4;
    localparam int CP  = 2;
    localparam int PD  = 3;
    localparam int HA  = 8;
    localparam int HFP = 2;
    localparam int HS  = 2;
    localparam int HBP = 2;
    localparam int VA  = 6;
    localparam int VFP = 1;
    localparam int VS  = 1;
    localparam int VBP = 2;
    localparam int HT  = HA + HFP + HS + HBP;
    localparam int VT  = VA + VFP + VS + VBP;
    localparam int NC  = GR * GC;
    localparam int FRAME_CYC = HT * VT * PD;
    localparam logic [23:0] FG = 24'hA0B0C0;
    localparam logic [23:0] BG = 24'h123456;

    typedef struct packed {
        logic        de;
        logic        hs;
        logic        vs;
        logic [23:0] rgb;
    } pix_t;

    typedef struct {
        int   stamp;
        logic fs;
        pix_t px;
    } exp_t;

    logic clk_74a = 1'b0;
    logic reset   = 1'b1;

    ngy_grid_renderer_if #(.N_CELLS(NC)) vid();

    ngy_grid_renderer #(
        .GRID_ROWS (GR),  .GRID_COLS (GC), .CELL_PX (CP), .PIX_DIV (PD),
        .H_ACTIVE  (HA),  .H_FP (HFP), .H_SYNC (HS), .H_BP (HBP),
        .V_ACTIVE  (VA),  .V_FP (VFP), .V_SYNC (VS), .V_BP (VBP),
        .FG_COLOR  (FG),  .BG_COLOR (BG)
    ) dut (
        .clk_74a (clk_74a),
        .reset   (reset),
        .vid     (vid)
    );

    always #5 clk_74a = ~clk_74a;

    int errors = 0;
    int checks = 0;

    // ---------------- reference model: cycle count -> pixel index -> raster position
    int          cyc  = 0;
    int          n    = 0;
    int          mx   = -1;
    int          my   = -1;
    logic [0:NC-1] fb = '0;
    bit          snap_pending = 0;
    pix_t        pipe[$];
    exp_t        sb[$];

    function automatic pix_t model_pixel(int x, int y, logic [0:NC-1] buf_v);
        pix_t p;
        logic act;
        act   = (x < HA) && (y < VA);
        p.de  = act;
        p.hs  = (x >= HA + HFP) && (x < HA + HFP + HS);
        p.vs  = (y >= VA + VFP) && (y < VA + VFP + VS);
        p.rgb = act ? (buf_v[(y / CP) * GC + (x / CP)] ? FG : BG) : 24'h0;
        return p;
    endfunction

    always @(posedge clk_74a) begin
        exp_t e;
        int   j;
        cyc++;
        if (reset) begin
            n = 0;
            fb = '0;
            snap_pending = 0;
            pipe.delete();
            sb.delete();
            mx = -1;
            my = -1;
        end else begin
            if (snap_pending) fb = vid.grid_ram;
            snap_pending = 0;
            n++;
            if (n % PD == PD - 1) begin
                j  = n / PD;
                mx = j % HT;
                my = (j / HT) % VT;
                pipe.push_back(model_pixel(mx, my, fb));
                e.stamp = cyc;
                e.fs    = (mx == 0) && (my == VA);
                e.px    = (pipe.size() > 2) ? pipe.pop_front() : '0;
                snap_pending = e.fs;
                sb.push_back(e);
            end
        end
    end

    // ---------------- monitor: pops on every pix_ce the DUT presents
    bit have_prev = 0;
    int ev_cnt = 0;
    int de_cnt = 0;

    always @(negedge clk_74a) begin
        exp_t e;
        pix_t got;
        if (reset) have_prev = 0;
        while (sb.size() > 0 && sb[0].stamp < cyc) begin
            checks++;
            errors++;
            $display("FAIL pix_ce_missing: expected pix_ce at cycle %0d, still absent at cycle %0d", sb[0].stamp, cyc);
            void'(sb.pop_front());
        end
        if (vid.pix_ce === 1'b1) begin
            got = {vid.video_de, vid.video_hs, vid.video_vs, vid.video_rgb};
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL pix_ce_unexpected: pix_ce=1 at cycle %0d, none expected", cyc);
            end else begin
                e = sb.pop_front();
                if (e.stamp != cyc || vid.frame_start !== e.fs || got !== e.px) begin
                    errors++;
                    $display("FAIL pixel: cyc=%0d/%0d got fs=%0b de=%0b hs=%0b vs=%0b rgb=%h required fs=%0b de=%0b hs=%0b vs=%0b rgb=%h",
                             cyc, e.stamp, vid.frame_start, got.de, got.hs, got.vs, got.rgb,
                             e.fs, e.px.de, e.px.hs, e.px.vs, e.px.rgb);
                end
            end
            if (vid.frame_start === 1'b1) begin
                if (have_prev) begin
                    checks++;
                    if (ev_cnt != HT * VT || de_cnt != HA * VA) begin
                        errors++;
                        $display("FAIL frame_counts: got pixels=%0d de=%0d required pixels=%0d de=%0d",
                                 ev_cnt, de_cnt, HT * VT, HA * VA);
                    end
                end
                have_prev = 1;
                ev_cnt = 0;
                de_cnt = 0;
            end
            ev_cnt++;
            if (vid.video_de === 1'b1) de_cnt++;
        end
    end

    // ---------------- stimulus
    task automatic check_idle(string name);
        checks++;
        if (vid.pix_ce !== 1'b0 || vid.frame_start !== 1'b0 || vid.video_rgb !== 24'h0 ||
            vid.video_hs !== 1'b0 || vid.video_vs !== 1'b0 || vid.video_de !== 1'b0) begin
            errors++;
            $display("FAIL %s: got ce=%0b fs=%0b rgb=%h hs=%0b vs=%0b de=%0b required all 0",
                     name, vid.pix_ce, vid.frame_start, vid.video_rgb,
                     vid.video_hs, vid.video_vs, vid.video_de);
        end
    endtask

    task automatic wait_pos(int x, int y);
        for (int i = 0; i < 2 * FRAME_CYC; i++) begin
            @(negedge clk_74a);
            if (mx == x && my == y) return;
        end
        checks++;
        errors++;
        $display("FAIL wait_pos: position (%0d,%0d) not reached, last (%0d,%0d)", x, y, mx, my);
    endtask

    task automatic run_frames(int k);
        repeat (k * FRAME_CYC) @(negedge clk_74a);
    endtask

    initial begin
        logic [0:NC-1] g;
        vid.grid_ram = '0;
        reset = 1'b1;
        repeat (5) @(negedge clk_74a);
        check_idle("reset_hold");
        reset = 1'b0;

        g = '0; g[0] = 1'b1;
        vid.grid_ram = g;
        run_frames(2);

        g = '0; g[NC-1] = 1'b1;
        vid.grid_ram = g;
        run_frames(2);

        wait_pos(0, 3);
        g[0] = 1'b1;
        vid.grid_ram = g;
        run_frames(2);

        for (int i = 0; i < 8; i++) begin
            repeat ($urandom_range(1, 300)) @(negedge clk_74a);
            vid.grid_ram = NC'($urandom);
        end
        run_frames(1);

        vid.grid_ram = '1;
        run_frames(1);
        wait_pos(5, 2);
        reset = 1'b1;
        @(negedge clk_74a);
        check_idle("reset_mid");
        reset = 1'b0;
        run_frames(2);

        for (int i = 0; i < 6; i++) begin
            repeat ($urandom_range(1, 400)) @(negedge clk_74a);
            vid.grid_ram = NC'($urandom);
        end
        run_frames(1);
        @(negedge clk_74a);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_ngy_grid_renderer
`default_nettype wire
